// File: rtl/bridge_pkg.sv
// Shared constants and types for the 2-bit-to-1-bit width bridge.
package bridge_pkg;
  localparam int BRIDGE_DW    = 2;
  localparam int BRIDGE_DEPTH = 4;

  typedef logic [BRIDGE_DW-1:0] sym_t;
endpackage

// File: rtl/bridge_fifo.sv
// Symbol storage for the bridge: circular buffer with registered full/empty.
module bridge_fifo
  import bridge_pkg::*;
#(
  parameter int DW    = BRIDGE_DW,
  parameter int DEPTH = BRIDGE_DEPTH
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          push,
  input  logic          pop_entry,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;

  // Fullness is judged on the start-of-cycle count, so a push into a full
  // buffer is dropped even when the same cycle retires an entry.
  assign push_ok = push & ~full;

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop_entry)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_entry})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok && !rst)
      mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
endmodule

// File: rtl/bridge.sv
// Width bridge top: buffers DW-bit symbols and serializes them LSB first.
module bridge
  import bridge_pkg::*;
#(
  parameter int DW    = BRIDGE_DW,
  parameter int DEPTH = BRIDGE_DEPTH
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          d,
  input  logic [DW-1:0] f,
  input  logic [1:0]    e,
  output logic          a,
  output logic          b,
  output logic          c
);
  localparam int IW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(DW-1);

  logic          clr;
  logic          pop_bit;
  logic          retire;
  logic [IW-1:0] bit_idx;
  logic [DW-1:0] dout;

  // Flush behaves exactly like reset and wins over any push or pop.
  assign clr     = rst | e[1];
  assign pop_bit = e[0] & ~b;
  assign retire  = pop_bit && (bit_idx == LAST_BIT);

  bridge_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .rst       (clr),
    .push      (d),
    .pop_entry (retire),
    .din       (f),
    .dout      (dout),
    .full      (a),
    .empty     (b)
  );

  always_ff @(posedge clock) begin
    if (clr) begin
      bit_idx <= '0;
      c       <= 1'b0;
    end else if (pop_bit) begin
      c       <= dout[bit_idx];
      bit_idx <= retire ? '0 : bit_idx + IW'(1);
    end
  end
endmodule

// File: tb/tb_bridge.sv
// Directed and randomized bench for bridge against a queue-based reference model.
module tb_bridge;
  import bridge_pkg::*;

  localparam int DW    = BRIDGE_DW;
  localparam int DEPTH = BRIDGE_DEPTH;

  logic          clock;
  logic          rst;
  logic          d;
  logic [DW-1:0] f;
  logic [1:0]    e;
  logic          a;
  logic          b;
  logic          c;

  int errors;
  int checks;

  // Reference model state
  sym_t q[$];
  int   pos;
  logic mc;

  bridge #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .rst   (rst),
    .d     (d),
    .f     (f),
    .e     (e),
    .a     (a),
    .b     (b),
    .c     (c)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare all outputs.
  task automatic step(input string tag, input logic r, input logic dv,
                      input logic [DW-1:0] fv, input logic [1:0] ev);
    bit was_full;
    bit was_empty;
    rst = r; d = dv; f = fv; e = ev;
    @(posedge clock);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (r || ev[1]) begin
      q.delete();
      pos = 0;
      mc  = 1'b0;
    end else begin
      if (ev[0] && !was_empty) begin
        mc = q[0][pos];
        pos++;
        if (pos == DW) begin
          void'(q.pop_front());
          pos = 0;
        end
      end
      if (dv && !was_full)
        q.push_back(fv);
    end
    #1;
    chk({tag, "_a"}, a, (q.size() == DEPTH));
    chk({tag, "_b"}, b, (q.size() == 0));
    chk({tag, "_c"}, c, mc);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    pos    = 0;
    mc     = 1'b0;
    rst = 1'b1; d = 1'b0; f = '0; e = 2'b00;

    // Reset
    step("rst0", 1, 0, 2'b00, 2'b00);
    step("rst1", 1, 0, 2'b00, 2'b00);
    chk("rst_a", a, 1'b0);
    chk("rst_b", b, 1'b1);
    chk("rst_c", c, 1'b0);

    // Single symbol
    step("single_push", 0, 1, 2'b10, 2'b00);
    chk("single_notempty", b, 1'b0);
    step("single_pop0", 0, 0, 2'b00, 2'b01);
    chk("single_bit0", c, 1'b0);
    step("single_pop1", 0, 0, 2'b00, 2'b01);
    chk("single_bit1", c, 1'b1);
    chk("single_empty", b, 1'b1);

    // Fill and overflow
    step("fill0", 0, 1, 2'b01, 2'b00);
    step("fill1", 0, 1, 2'b10, 2'b00);
    step("fill2", 0, 1, 2'b11, 2'b00);
    step("fill3", 0, 1, 2'b00, 2'b00);
    chk("fill_full", a, 1'b1);
    step("overflow", 0, 1, 2'b11, 2'b00);
    chk("overflow_full", a, 1'b1);
    begin
      logic [7:0] exp_bits;
      exp_bits = 8'b0011_1001; // bit i is the i-th expected serial bit
      for (int i = 0; i < 8; i++) begin
        step("drain", 0, 0, 2'b00, 2'b01);
        chk($sformatf("drain_bit%0d", i), c, exp_bits[i]);
      end
    end
    chk("drain_empty", b, 1'b1);

    // Empty pop holds c
    step("prime_push", 0, 1, 2'b11, 2'b00);
    step("prime_pop0", 0, 0, 2'b00, 2'b01);
    step("prime_pop1", 0, 0, 2'b00, 2'b01);
    for (int i = 0; i < 3; i++) begin
      step("empty_pop", 0, 0, 2'b00, 2'b01);
      chk("empty_pop_hold", c, 1'b1);
      chk("empty_pop_a", a, 1'b0);
    end

    // Flush priority over push
    step("fl_push0", 0, 1, 2'b01, 2'b00);
    step("fl_push1", 0, 1, 2'b10, 2'b00);
    step("flush", 0, 1, 2'b11, 2'b11);
    chk("flush_empty", b, 1'b1);
    chk("flush_c", c, 1'b0);
    step("post_flush", 0, 0, 2'b00, 2'b00);
    chk("post_flush_empty", b, 1'b1);

    // Simultaneous push and retire
    step("sim_push", 0, 1, 2'b10, 2'b00);
    step("sim_pop0", 0, 0, 2'b00, 2'b01);
    step("sim_both", 0, 1, 2'b01, 2'b11 & 2'b01);
    chk("sim_both_c", c, 1'b1);
    chk("sim_both_b", b, 1'b0);
    step("sim_next0", 0, 0, 2'b00, 2'b01);
    chk("sim_next0_c", c, 1'b1);
    step("sim_next1", 0, 0, 2'b00, 2'b01);
    chk("sim_next1_c", c, 1'b0);
    chk("sim_next_empty", b, 1'b1);

    // Mid-stream reset
    step("mid_push0", 0, 1, 2'b11, 2'b00);
    step("mid_push1", 0, 1, 2'b01, 2'b00);
    step("mid_push2", 0, 1, 2'b10, 2'b00);
    step("mid_pop", 0, 0, 2'b00, 2'b01);
    step("mid_rst", 1, 0, 2'b00, 2'b00);
    chk("mid_rst_a", a, 1'b0);
    chk("mid_rst_b", b, 1'b1);
    chk("mid_rst_c", c, 1'b0);
    step("mid_after", 0, 0, 2'b00, 2'b01);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic          rr;
      logic          dd;
      logic [DW-1:0] ff;
      logic [1:0]    ee;
      rr    = ($urandom_range(0, 63) == 0);
      dd    = ($urandom_range(0, 99) < 55);
      ff    = DW'($urandom);
      ee[0] = ($urandom_range(0, 99) < 60);
      ee[1] = ($urandom_range(0, 31) == 0);
      step("rand", rr, dd, ff, ee);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
